// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter slice.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE is the one-cycle arbitration slot, BURST owns the port
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_MAX_BURST  = 8;

    // Width of a requester index; kept at least one bit so a single
    // requester still gets a legal vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fifo_arb_pkg

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes, FIFO write port and arbiter status.
// The slave modport is the arbiter's view; master is the view of whoever
// drives the requesters and the FIFO full flag.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int GW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [DATA_WIDTH-1:0]              fifo_wr_data;
    logic                               fifo_wr_en;
    logic                               fifo_wr_full;
    logic [GW-1:0]                      grant_id;
    logic                               busy;

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        input  fifo_wr_full,
        output req_ready,
        output fifo_wr_data,
        output fifo_wr_en,
        output grant_id,
        output busy
    );

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        output fifo_wr_full,
        input  req_ready,
        input  fifo_wr_data,
        input  fifo_wr_en,
        input  grant_id,
        input  busy
    );

endinterface : fifo_wr_arbiter_if

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// found when scanning upward from rr_ptr+1, wrapping past NUM_REQ-1 to 0.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [idx_width(NUM_REQ)-1:0] rr_ptr_i,
    output logic [idx_width(NUM_REQ)-1:0] winner_o,
    output logic                          any_req_o
);
    localparam int GW = idx_width(NUM_REQ);

    int   idx_c;
    logic found_c;

    // Scan all requesters once in rotated order; the first hit wins and
    // later hits are ignored, so the pointer position sets the priority.
    always_comb begin
        winner_o = '0;
        found_c  = 1'b0;
        idx_c    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_c = int'(rr_ptr_i) + k;
            if (idx_c >= NUM_REQ) begin
                idx_c = idx_c - NUM_REQ;
            end
            if (!found_c && req_i[idx_c[GW-1:0]]) begin
                winner_o = GW'(idx_c);
                found_c  = 1'b1;
            end
        end
    end

    assign any_req_o = |req_i;

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// Shares a single FIFO write port among NUM_REQ burst requesters.
// Bursts are granted round-robin with one idle arbitration cycle between
// them; a grant lasts until an accepted last beat or MAX_BURST beats.
// The write path is combinational from the granted requester so a beat
// reaches the FIFO in the same cycle it is handshaken.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic              wr_clk,
    input  logic              wreset,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int GW = idx_width(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  accept_c;
    logic [NUM_REQ-1:0]    req_ready_c;
    logic                  fifo_wr_en_c;
    logic [DATA_WIDTH-1:0] fifo_wr_data_c;
    logic                  busy_c;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i     (bus.req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (pick_idx),
        .any_req_o (pick_any)
    );

    // State registers; reset parks the pointer on the last requester so
    // that index 0 wins the first arbitration.
    always_ff @(posedge wr_clk or posedge wreset) begin
        if (wreset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= GW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Next-state and handshake outputs; a stalled FIFO blocks acceptance so
    // the count and state simply hold, and a requester that drops valid
    // keeps its grant until it finishes the burst.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        beat_cnt_d     = beat_cnt_q;
        accept_c       = 1'b0;
        req_ready_c    = '0;
        fifo_wr_en_c   = 1'b0;
        fifo_wr_data_c = '0;
        busy_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            BURST: begin
                busy_c               = 1'b1;
                req_ready_c[grant_q] = ~bus.fifo_wr_full;
                accept_c             = bus.req_valid[grant_q] & ~bus.fifo_wr_full;
                fifo_wr_en_c         = accept_c;
                if (accept_c) begin
                    fifo_wr_data_c = bus.req_data[grant_q];
                    beat_cnt_d     = beat_cnt_q + CW'(1);
                    if (bus.req_last[grant_q] || (beat_cnt_d == CW'(MAX_BURST))) begin
                        state_d  = IDLE;
                        rr_ptr_d = grant_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.fifo_wr_en   = fifo_wr_en_c;
    assign bus.fifo_wr_data = fifo_wr_data_c;
    assign bus.grant_id     = grant_q;
    assign bus.busy         = busy_c;

endmodule : fifo_wr_arbiter

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a fixed vector table for the
// basic burst and round-robin sequences, hand-written multi-cycle corner
// cases, and a randomized run checked against a transaction-level model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         full;
        logic [N-1:0] expReady;
        logic         expEn;
        logic [1:0]   expGrant;
        logic         expBusy;
    } vec_t;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .wr_clk (clk),
        .wreset (rst),
        .bus    (bus)
    );

    int testsRun  = 0;
    int failCount = 0;

    // Reference model state: who owns the port, where the rotation resumes
    // and how many beats the current owner has written.
    bit mBusy;
    int mGrant;
    int mPtr;
    int mBeats;

    logic [DW-1:0] wrLog[$];
    int            grantsSeen;
    logic          prevBusy;

    vec_t vecs[$];

    // Free-running write clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something stalls the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string what, input logic [DW-1:0] got, input logic [DW-1:0] want);
        testsRun++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] eReady, input logic eEn,
                               input logic [DW-1:0] eData, input logic [1:0] eGrant, input logic eBusy);
        cmp({tag, " req_ready"},    DW'(bus.req_ready),  DW'(eReady));
        cmp({tag, " fifo_wr_en"},   DW'(bus.fifo_wr_en), DW'(eEn));
        cmp({tag, " fifo_wr_data"}, bus.fifo_wr_data,    eData);
        cmp({tag, " grant_id"},     DW'(bus.grant_id),   DW'(eGrant));
        cmp({tag, " busy"},         DW'(bus.busy),       DW'(eBusy));
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic f,
                                 input logic [N-1:0][DW-1:0] d);
        bus.req_valid    = v;
        bus.req_last     = l;
        bus.fifo_wr_full = f;
        bus.req_data     = d;
    endtask

    task automatic modelReset();
        mBusy  = 1'b0;
        mGrant = 0;
        mPtr   = N - 1;
        mBeats = 0;
    endtask

    // One checked clock cycle: compare at the falling edge, then let the
    // model consume the same inputs the DUT sees at the rising edge.
    task automatic stepChecked(input string tag, output bit accepted);
        logic [N-1:0]  eReady;
        logic          eEn;
        logic [DW-1:0] eData;
        @(negedge clk);
        eReady = '0;
        eEn    = 1'b0;
        eData  = '0;
        if (mBusy) begin
            if (!bus.fifo_wr_full) eReady[mGrant] = 1'b1;
            eEn = bus.req_valid[mGrant] && !bus.fifo_wr_full;
            if (eEn) eData = bus.req_data[mGrant];
        end
        checkOutput(tag, eReady, eEn, eData, 2'(mGrant), mBusy);
        if (bus.fifo_wr_en) wrLog.push_back(bus.fifo_wr_data);
        if (bus.busy && !prevBusy) grantsSeen++;
        prevBusy = bus.busy;
        accepted = eEn;
        @(posedge clk);
        if (!mBusy) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (mPtr + k) % N;
                if (bus.req_valid[i]) begin
                    mGrant = i;
                    mBeats = 0;
                    mBusy  = 1'b1;
                    break;
                end
            end
        end else if (eEn) begin
            mBeats++;
            if (bus.req_last[mGrant] || mBeats == MB) begin
                mBusy = 1'b0;
                mPtr  = mGrant;
            end
        end
        #1;
    endtask

    task automatic doReset();
        logic [N-1:0][DW-1:0] z;
        z   = '0;
        rst = 1'b1;
        applyStimulus('0, '0, 1'b0, z);
        @(posedge clk);
        #1;
        checkOutput("reset", '0, 1'b0, '0, 2'd0, 1'b0);
        rst = 1'b0;
        modelReset();
        wrLog.delete();
        grantsSeen = 0;
        prevBusy   = 1'b0;
    endtask

    task automatic addVec(input logic r, input logic [N-1:0] v, input logic [N-1:0] l, input logic f,
                          input logic [N-1:0] er, input logic ee, input logic [1:0] eg, input logic eb);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.full = f;
        t.expReady = er; t.expEn = ee; t.expGrant = eg; t.expBusy = eb;
        vecs.push_back(t);
    endtask

    initial begin
        logic [N-1:0][DW-1:0] d;
        logic [N-1:0]         v, l;
        logic                 f;
        logic [DW-1:0]        eData;
        bit                   acc;
        int                   b, cyc, fullLeft;

        rst = 1'b1;
        d   = '0;
        applyStimulus('0, '0, 1'b0, d);
        modelReset();
        grantsSeen = 0;
        prevBusy   = 1'b0;

        // rst valid last full | ready en grant busy
        addVec(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // requester 0, three beats, last on the third
        addVec(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        addVec(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 1);
        addVec(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, 2'd0, 1);
        addVec(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 2'd0, 1);
        addVec(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);
        // fresh reset, all requesters with single-beat bursts
        addVec(1, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 2'd0, 1);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 2'd1, 1);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd1, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 2'd2, 1);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd2, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 2'd3, 1);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd3, 0);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 2'd0, 1);
        addVec(0, 4'b1111, 4'b1111, 0, 4'b0000, 0, 2'd0, 0);
        addVec(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd0, 0);

        @(posedge clk);
        #1;
        for (int e = 0; e < vecs.size(); e++) begin
            rst = vecs[e].rst;
            for (int i = 0; i < N; i++) d[i] = 32'hC000_0000 | (i << 16) | e;
            applyStimulus(vecs[e].valid, vecs[e].last, vecs[e].full, d);
            @(negedge clk);
            eData = vecs[e].expEn ? d[vecs[e].expGrant] : '0;
            checkOutput($sformatf("vec%0d", e), vecs[e].expReady, vecs[e].expEn, eData,
                        vecs[e].expGrant, vecs[e].expBusy);
            @(posedge clk);
            #1;
        end

        // Requester 2 streams 12 beats with no last: split at MAX_BURST
        doReset();
        b = 0;
        cyc = 0;
        while (b < 12 && cyc < 60) begin
            d = '0;
            d[2] = 32'h2000_0000 | b;
            applyStimulus(4'b0100, 4'b0000, 1'b0, d);
            stepChecked("long", acc);
            if (acc) b++;
            cyc++;
        end
        cmp("long beats sent", DW'(b), DW'(12));
        cmp("long writes", DW'(wrLog.size()), DW'(12));
        for (int j = 0; j < wrLog.size(); j++) cmp($sformatf("long data%0d", j), wrLog[j], 32'h2000_0000 | j);
        cmp("long grants", DW'(grantsSeen), DW'(2));
        applyStimulus('0, '0, 1'b0, '0);
        stepChecked("long hold", acc);
        stepChecked("long hold", acc);

        // Requester 1 six-beat burst with a five-cycle FIFO stall after beat 2
        doReset();
        b = 0;
        cyc = 0;
        fullLeft = 5;
        while (b < 6 && cyc < 60) begin
            f = (b == 2) && (fullLeft > 0);
            if (f) fullLeft--;
            d = '0;
            d[1] = 32'h1100_0000 | b;
            l = (b == 5) ? 4'b0010 : 4'b0000;
            applyStimulus(4'b0010, l, f, d);
            stepChecked(f ? "stall full" : "stall", acc);
            if (acc) b++;
            cyc++;
        end
        cmp("stall beats sent", DW'(b), DW'(6));
        cmp("stall cycles used", DW'(fullLeft), DW'(0));
        cmp("stall writes", DW'(wrLog.size()), DW'(6));
        for (int j = 0; j < wrLog.size(); j++) cmp($sformatf("stall data%0d", j), wrLog[j], 32'h1100_0000 | j);
        applyStimulus('0, '0, 1'b0, '0);
        stepChecked("stall end", acc);

        // Reset pulse in the middle of a four-beat burst from requester 3
        doReset();
        d = '0;
        d[3] = 32'h3300_0000;
        d[1] = 32'h0110_0000;
        applyStimulus(4'b1000, 4'b0000, 1'b0, d);
        stepChecked("pre rst", acc);
        stepChecked("pre rst", acc);
        stepChecked("pre rst", acc);
        cmp("pre rst busy", DW'(bus.busy), DW'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst", '0, 1'b0, '0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        prevBusy = 1'b0;
        applyStimulus(4'b1010, 4'b0000, 1'b0, d);
        stepChecked("post rst", acc);
        stepChecked("post rst", acc);
        cmp("post rst grant", DW'(bus.grant_id), DW'(1));

        // Randomized traffic against the model, with occasional resets
        doReset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) doReset();
            v = N'($urandom);
            for (int i = 0; i < N; i++) l[i] = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) d[i] = $urandom;
            applyStimulus(v, l, f, d);
            stepChecked("rand", acc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
